// File: rtl/capture_fifo.sv
// Circular-buffer FIFO for captured print-mechanism samples, with registered
// read port, full/empty/count status and a sticky overflow flag.

module incrementer #(
  parameter int WIDTH     = 4,
  parameter int MAX_VALUE = 15,
  parameter int INCREMENT = 1
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] next_o
);

  localparam int unsigned WRAP_FROM = MAX_VALUE - INCREMENT + 1;
  localparam int unsigned MODULUS   = MAX_VALUE + 1;

  int unsigned value_ext;
  int unsigned sum;

  // Wraps to the start of the range past MAX_VALUE instead of at 2**WIDTH,
  // so pointer ranges need not be a power of two.
  always_comb begin
    value_ext = 32'(value_i);
    sum       = value_ext + INCREMENT;
    if (value_ext >= WRAP_FROM) begin
      next_o = WIDTH'(sum - MODULUS);
    end else begin
      next_o = WIDTH'(sum);
    end
  end

endmodule

module capture_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       write_en,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic                       read_en,
  output logic [DATA_WIDTH-1:0]      read_data,
  output logic                       read_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, wr_ptr_inc;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, rd_ptr_inc;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;

  logic full_w, empty_w;
  logic wr_accept, rd_accept;

  incrementer #(
    .WIDTH    (PTR_W),
    .MAX_VALUE(DEPTH - 1),
    .INCREMENT(1)
  ) u_wr_inc (
    .value_i(wr_ptr_q),
    .next_o (wr_ptr_inc)
  );

  incrementer #(
    .WIDTH    (PTR_W),
    .MAX_VALUE(DEPTH - 1),
    .INCREMENT(1)
  ) u_rd_inc (
    .value_i(rd_ptr_q),
    .next_o (rd_ptr_inc)
  );

  // Status is decoded from the registered count only, never from the requests.
  assign full_w    = (count_q == CNT_W'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign wr_accept = write_en & ~full_w;
  assign rd_accept = read_en & ~empty_w;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      read_data_d = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_inc;
      end
      if (write_en && full_w) begin
        overflow_d = 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_d     = rd_ptr_inc;
        read_data_d  = mem_q[rd_ptr_q];
        read_valid_d = 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone define
  // which words are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && !clear && wr_accept) begin
      mem_q[wr_ptr_q] <= write_data;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign full       = full_w;
  assign empty      = empty_w;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/capture_fifo.md
# capture_fifo

Synchronous circular-buffer FIFO that buffers captured print-mechanism samples between the capture front end and the host-side readout. Read and write pointers advance through `incrementer` instances with `MAX_VALUE = DEPTH-1`, so `DEPTH` need not be a power of two. It provides full/empty/count status, a registered read port, and a sticky overflow flag for writes lost while full.

## Interface
- `DATA_WIDTH`, 8: width of each stored word.
- `DEPTH`, 16: number of words stored, with 2 ≤ DEPTH ≤ 65535. Any value is legal, including non-powers of two.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `clear` input 1: synchronous flush. Empties the FIFO and clears `overflow`; memory contents are not erased.
- `write_en` input 1: write request for this cycle.
- `write_data` input DATA_WIDTH: word to store.
- `read_en` input 1: read request for this cycle.
- `read_data` output DATA_WIDTH: registered output word.
- `read_valid` output 1: one-cycle pulse meaning `read_data` holds a newly popped word.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `count` output $clog2(DEPTH+1): words currently stored.
- `overflow` output 1: sticky flag. Set when a write is rejected because the FIFO is full.

## Operation
- Storage: DEPTH × DATA_WIDTH array, no reset on memory.
- Pointers:
  - `wr_ptr` and `rd_ptr` are each $clog2(DEPTH) bits.
  - The next value of each comes from an `incrementer` (`MAX_VALUE = DEPTH-1`, `INCREMENT = 1`).
  - Sequence is 0, 1, …, DEPTH-1, 0. No modulo arithmetic elsewhere.
- Write acceptance: `wr_accept = write_en & ~full`, using `full` from before the edge. On accept:
  - mem[wr_ptr] ← write_data
  - wr_ptr ← next value
- Read acceptance: `rd_accept = read_en & ~empty`, using `empty` from before the edge. On accept:
  - read_data ← mem[rd_ptr]
  - rd_ptr ← next value
  - read_valid ← 1
- `read_valid` is 0 on every cycle without an accepted read. `read_data` holds its last value when no read is accepted.
- Count update:
  - +1 on write accept only.
  - −1 on read accept only.
  - Unchanged when both or neither are accepted.
- Full with `write_en` and `read_en` together: the read is accepted, the write is rejected, and `overflow` is set. The write is not retried.
- Empty with `write_en` and `read_en` together: the write is accepted, the read is rejected (`read_valid` = 0). There is no bypass from write to read.
- Rejected read while empty: no flag, no state change.
- `full`, `empty` and `count` are registered, or decoded purely from the registered count. They never depend combinationally on `write_en` or `read_en`.
- `clear` or `rst` at the edge sets:
  - wr_ptr = rd_ptr = 0, count = 0
  - overflow = 0, read_valid = 0, read_data = 0
  - Any write or read requested in the same cycle is discarded.
  - `rst` takes precedence over `clear`; both have identical effect.

## Timing
- Reset values: read_data = 0, read_valid = 0, full = 0, empty = 1, count = 0, overflow = 0.
- Write-to-status latency is 1 cycle. A write accepted at edge N shows in `count`, `empty` and `full` after edge N.
- Read latency is 1 cycle. A read accepted at edge N presents the word on `read_data` with `read_valid` = 1 from edge N until edge N+1.
- Write-to-readable latency: a word written at edge N can first be read-accepted at edge N+1 and appears on `read_data` after edge N+1.
- Sustained throughput is one write and one read per cycle when 0 < count < DEPTH.
- `overflow` sets on the edge of the rejected write and stays high until `rst` or `clear`.
- Reset or clear in the middle of a burst takes effect at that edge. Status is valid from the next cycle.

## Test plan
- Reset, then idle: empty = 1, full = 0, count = 0, read_valid = 0, read_data = 0, overflow = 0.
- DEPTH = 5: write 0x11..0x15 on 5 cycles → full = 1, count = 5. A sixth write of 0x16 → overflow = 1, count stays 5. Read 5 → 0x11..0x15 in order, read_valid high 5 cycles, then empty = 1.
- DEPTH = 5, pointer wrap: write 3, read 3, then write 4 (0xA0..0xA3) and read 4 → 0xA0..0xA3 returned in order across the 4→0 wrap; count never exceeds 4.
- Simultaneous read and write:
  - At count = 2 → count stays 2 and data order is preserved.
  - At empty → count becomes 1, read_valid = 0.
  - At full → the read returns the oldest word, the write is dropped, overflow = 1, count = DEPTH−1.
- Read while empty for 3 cycles → read_valid = 0, count = 0, pointers unchanged. A subsequent write and read of 0x5A → 0x5A returned.
- With count = 3 and overflow = 1, assert `clear` together with `write_en` → count = 0, empty = 1, overflow = 0, and the write is not stored. Repeat the same check with `rst`.
